transpose_arbiter: RTL and testbench
====================================

// Module: transpose_arbiter
// PURPOSE
//  Shares one transpose engine between two AXI-Stream requesters. A whole matrix is granted at a time:
//  the arbiter feeds MATRIX_BEATS input beats from the owner into the engine, then routes the
//  MATRIX_BEATS result beats back to the same requester's output stream. Grants are round-robin per
//  matrix. The block sits between the requesters (e.g. DCT row/column passes) and the transpose engine.
// PARAMETERS
//  VALUE_WIDTH      17                               signed element width
//  AXIS_DATA_WIDTH  8*((VALUE_WIDTH-1)/8+1)          byte-padded TDATA width
//  MATRIX_DIM       8                                matrix side; MATRIX_BEATS = MATRIX_DIM**2 (localparam)
// PORTS
//  i_clk               in   1                clock
//  i_reset             in   1                synchronous, active-high reset
//  i_s0_axis_TVALID    in   1                requester 0 input beat valid
//  o_s0_axis_TREADY    out  1                requester 0 input ready
//  i_s0_axis_TDATA     in   AXIS_DATA_WIDTH  requester 0 input data
//  i_s1_axis_TVALID/o_s1_axis_TREADY/i_s1_axis_TDATA   same as above, for requester 1
//  o_eng_axis_TVALID   out  1                beat to engine valid
//  i_eng_axis_TREADY   in   1                engine input ready
//  o_eng_axis_TDATA    out  AXIS_DATA_WIDTH  beat to engine
//  o_eng_axis_TLAST    out  1                last beat of matrix to engine
//  i_eng_axis_TVALID   in   1                engine result valid
//  o_eng_axis_TREADY   out  1                ready for engine result
//  i_eng_axis_TDATA    in   AXIS_DATA_WIDTH  engine result data
//  o_m0_axis_TVALID    out  1                result to requester 0 valid
//  i_m0_axis_TREADY    in   1                requester 0 result ready
//  o_m0_axis_TDATA     out  AXIS_DATA_WIDTH  result data to requester 0
//  o_m0_axis_TLAST     out  1                last result beat to requester 0
//  o_m1_axis_TVALID/i_m1_axis_TREADY/o_m1_axis_TDATA/o_m1_axis_TLAST   same as above, for requester 1
//  o_busy              out  1                state != IDLE
//  o_owner             out  1                current or last granted requester
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, owner=0, in_cnt=out_cnt=0. All TVALID/TREADY/TLAST outputs are 0,
//    all TDATA outputs are 0, and o_busy=0.
//  - Data paths are combinational muxes with zero added latency. Unselected TDATA outputs are driven to 0.
//  - IDLE: all TREADY outputs are 0. If exactly one i_sX TVALID is high, that requester is granted.
//    If both are high, requester rr_ptr is granted. The arbiter latches owner and moves to FEED on the
//    next cycle. It takes no beat in IDLE.
//  - FEED:
//    - o_eng TVALID = i_s[owner] TVALID and o_s[owner] TREADY = i_eng TREADY. The other requester's TREADY is 0.
//    - in_cnt increments on each handshake. o_eng_axis_TLAST = (in_cnt == MATRIX_BEATS-1).
//    - On the last handshake: in_cnt clears and the state goes to DRAIN.
//    - o_eng_axis_TREADY = 0 throughout, so early engine output is held off.
//  - DRAIN:
//    - o_m[owner] TVALID = i_eng TVALID and o_eng_axis_TREADY = i_m[owner] TREADY.
//    - The other o_m TVALID is 0 and all o_sX TREADY are 0.
//    - out_cnt counts handshakes. o_m[owner] TLAST = (out_cnt == MATRIX_BEATS-1).
//    - On the last handshake: out_cnt clears, rr_ptr = ~owner, and the state goes to IDLE.
//  - Requester TLAST is not consumed; beat count alone delimits a matrix.
//  - Only one matrix is in flight at a time; a new grant is possible only after DRAIN completes.
//  - Stall at any point (TVALID or TREADY low) freezes the counters and state. No beat is dropped or duplicated.
//  - Reset mid-matrix: the state returns to IDLE on the next edge and the partial matrix is discarded.
//    The engine shares i_reset.
//  - Fairness: with both requesting continuously, owners alternate 0,1,0,1 per matrix.
// TESTING
//  1. Only s0 sends 1..64 -> engine receives 64 beats with TLAST on value 64. m0 returns 64 beats with
//     TLAST on the 64th. m1 TVALID is never 1. o_busy is 0 afterwards.
//  2. s0 and s1 are both valid from reset -> s0 matrix first (s1 TREADY=0 throughout), then s1 matrix.
//     o_owner sequence is 0,1,0.
//  3. i_m0 TREADY toggles every cycle in DRAIN -> o_eng TREADY mirrors it. Exactly 64 results are
//     delivered, in order.
//  4. i_eng TREADY is low for 10 cycles after beat 20 -> o_s0 TREADY is low, in_cnt holds 20, and TDATA
//     holds beat 21.
//  5. i_reset pulses during FEED at beat 30 -> next cycle IDLE: all TVALID/TREADY are 0 and o_busy is 0.
//     The next grant, with both valid, goes to s0.
//  6. Engine asserts TVALID during FEED -> o_eng TREADY stays 0 and no o_m TVALID is asserted
//     until DRAIN.

Source files
------------

// File: rtl/transpose_arbiter_if.sv
// Stream bundle between the transpose arbiter, its two requesters and the shared engine.
// The arbiter connects through the slave modport; the surrounding fabric uses master.
interface transpose_arbiter_if #(
  parameter int AXIS_DATA_WIDTH = 24
);
  logic                       i_s0_axis_TVALID;
  logic                       o_s0_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] i_s0_axis_TDATA;
  logic                       i_s1_axis_TVALID;
  logic                       o_s1_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] i_s1_axis_TDATA;
  logic                       o_eng_axis_TVALID;
  logic                       i_eng_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] o_eng_axis_TDATA;
  logic                       o_eng_axis_TLAST;
  logic                       i_eng_axis_TVALID;
  logic                       o_eng_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] i_eng_axis_TDATA;
  logic                       o_m0_axis_TVALID;
  logic                       i_m0_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] o_m0_axis_TDATA;
  logic                       o_m0_axis_TLAST;
  logic                       o_m1_axis_TVALID;
  logic                       i_m1_axis_TREADY;
  logic [AXIS_DATA_WIDTH-1:0] o_m1_axis_TDATA;
  logic                       o_m1_axis_TLAST;
  logic                       o_busy;
  logic                       o_owner;

  modport slave (
    input  i_s0_axis_TVALID, i_s0_axis_TDATA, i_s1_axis_TVALID, i_s1_axis_TDATA,
    input  i_eng_axis_TREADY, i_eng_axis_TVALID, i_eng_axis_TDATA,
    input  i_m0_axis_TREADY, i_m1_axis_TREADY,
    output o_s0_axis_TREADY, o_s1_axis_TREADY,
    output o_eng_axis_TVALID, o_eng_axis_TDATA, o_eng_axis_TLAST, o_eng_axis_TREADY,
    output o_m0_axis_TVALID, o_m0_axis_TDATA, o_m0_axis_TLAST,
    output o_m1_axis_TVALID, o_m1_axis_TDATA, o_m1_axis_TLAST,
    output o_busy, o_owner
  );

  modport master (
    output i_s0_axis_TVALID, i_s0_axis_TDATA, i_s1_axis_TVALID, i_s1_axis_TDATA,
    output i_eng_axis_TREADY, i_eng_axis_TVALID, i_eng_axis_TDATA,
    output i_m0_axis_TREADY, i_m1_axis_TREADY,
    input  o_s0_axis_TREADY, o_s1_axis_TREADY,
    input  o_eng_axis_TVALID, o_eng_axis_TDATA, o_eng_axis_TLAST, o_eng_axis_TREADY,
    input  o_m0_axis_TVALID, o_m0_axis_TDATA, o_m0_axis_TLAST,
    input  o_m1_axis_TVALID, o_m1_axis_TDATA, o_m1_axis_TLAST,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/transpose_arbiter.sv
// Round-robin sharing of one transpose engine between two requesters, one whole matrix at a time:
// FEED pushes the owner's beats into the engine, DRAIN returns the engine's beats to that owner.
module transpose_arbiter #(
  parameter int VALUE_WIDTH     = 17,
  parameter int AXIS_DATA_WIDTH = 8 * ((VALUE_WIDTH - 1) / 8 + 1),
  parameter int MATRIX_DIM      = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  transpose_arbiter_if.slave  bus
);
  localparam int MATRIX_BEATS = MATRIX_DIM * MATRIX_DIM;
  localparam int CNT_W        = (MATRIX_BEATS > 1) ? $clog2(MATRIX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MATRIX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic                       s0_rdy, s1_rdy;
  logic                       eng_vld, eng_last, eng_rdy;
  logic [AXIS_DATA_WIDTH-1:0] eng_data;
  logic                       m0_vld, m0_last, m1_vld, m1_last;
  logic [AXIS_DATA_WIDTH-1:0] m0_data, m1_data;
  logic                       src_vld;
  logic [AXIS_DATA_WIDTH-1:0] src_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Owner's source stream, used only while feeding the engine.
  assign src_vld  = owner_q ? bus.i_s1_axis_TVALID : bus.i_s0_axis_TVALID;
  assign src_data = owner_q ? bus.i_s1_axis_TDATA  : bus.i_s0_axis_TDATA;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    s0_rdy    = 1'b0;
    s1_rdy    = 1'b0;
    eng_vld   = 1'b0;
    eng_last  = 1'b0;
    eng_data  = '0;
    eng_rdy   = 1'b0;
    m0_vld    = 1'b0;
    m0_last   = 1'b0;
    m0_data   = '0;
    m1_vld    = 1'b0;
    m1_last   = 1'b0;
    m1_data   = '0;
    unique case (state_q)
      IDLE: begin
        // Grant only; the first beat is taken once FEED is entered.
        if (bus.i_s0_axis_TVALID || bus.i_s1_axis_TVALID) begin
          owner_d = (bus.i_s0_axis_TVALID && bus.i_s1_axis_TVALID) ? rr_q : bus.i_s1_axis_TVALID;
          state_d = FEED;
        end
      end
      FEED: begin
        eng_vld  = src_vld;
        eng_data = src_data;
        eng_last = (in_cnt_q == LAST);
        s0_rdy   = !owner_q && bus.i_eng_axis_TREADY;
        s1_rdy   = owner_q && bus.i_eng_axis_TREADY;
        if (src_vld && bus.i_eng_axis_TREADY) begin
          if (in_cnt_q == LAST) begin
            in_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        eng_rdy = owner_q ? bus.i_m1_axis_TREADY : bus.i_m0_axis_TREADY;
        m0_vld  = !owner_q && bus.i_eng_axis_TVALID;
        m1_vld  = owner_q && bus.i_eng_axis_TVALID;
        m0_data = owner_q ? '0 : bus.i_eng_axis_TDATA;
        m1_data = owner_q ? bus.i_eng_axis_TDATA : '0;
        m0_last = !owner_q && (out_cnt_q == LAST);
        m1_last = owner_q && (out_cnt_q == LAST);
        if (bus.i_eng_axis_TVALID && eng_rdy) begin
          if (out_cnt_q == LAST) begin
            out_cnt_d = '0;
            rr_d      = ~owner_q;
            state_d   = IDLE;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_s0_axis_TREADY  = s0_rdy;
  assign bus.o_s1_axis_TREADY  = s1_rdy;
  assign bus.o_eng_axis_TVALID = eng_vld;
  assign bus.o_eng_axis_TDATA  = eng_data;
  assign bus.o_eng_axis_TLAST  = eng_last;
  assign bus.o_eng_axis_TREADY = eng_rdy;
  assign bus.o_m0_axis_TVALID  = m0_vld;
  assign bus.o_m0_axis_TDATA   = m0_data;
  assign bus.o_m0_axis_TLAST   = m0_last;
  assign bus.o_m1_axis_TVALID  = m1_vld;
  assign bus.o_m1_axis_TDATA   = m1_data;
  assign bus.o_m1_axis_TLAST   = m1_last;
  assign bus.o_busy            = (state_q != IDLE);
  assign bus.o_owner           = owner_q;
endmodule

// File: tb/tb_transpose_arbiter.sv
// Directed bench for transpose_arbiter: two scripted requesters, a transposing engine model and
// two result sinks, all stepped one cycle at a time.
module tb_transpose_arbiter;
  localparam int W = 24;
  localparam int D = 8;
  localparam int N = D * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  transpose_arbiter_if #(.AXIS_DATA_WIDTH(W)) bus ();
  transpose_arbiter #(.VALUE_WIDTH(17), .AXIS_DATA_WIDTH(W), .MATRIX_DIM(D)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  bit s0_en, s1_en, eng_rdy, eng_force, m0_rdy, m1_rdy, m0_tog, busy_prev;
  int s0_idx, s1_idx, s0_lim, s1_lim, base0, base1;
  logic [W-1:0] eng_buf [N];
  int eng_cnt, eng_oidx;
  logic [W-1:0] eng_q[$], m0_q[$], m1_q[$];
  bit eng_tl[$], m0_tl[$], m1_tl[$];
  int owner_log[$];
  int m1_vld_seen, cross_rdy, mirror_bad, drain_cyc, junk_taken;

  function automatic int tp(int k);
    return (k % D) * D + k / D;
  endfunction

  task automatic clr();
    s0_en = 0; s1_en = 0; eng_rdy = 1; eng_force = 0; m0_rdy = 1; m1_rdy = 1; m0_tog = 0;
    s0_idx = 0; s1_idx = 0; s0_lim = N; s1_lim = N; base0 = 1; base1 = 1001;
    eng_cnt = 0; eng_oidx = 0; busy_prev = 0;
    eng_q.delete(); m0_q.delete(); m1_q.delete();
    eng_tl.delete(); m0_tl.delete(); m1_tl.delete(); owner_log.delete();
    m1_vld_seen = 0; cross_rdy = 0; mirror_bad = 0; drain_cyc = 0; junk_taken = 0;
  endtask

  task automatic drive();
    bus.i_s0_axis_TVALID = s0_en && (s0_idx < s0_lim);
    bus.i_s0_axis_TDATA  = W'(base0 + s0_idx);
    bus.i_s1_axis_TVALID = s1_en && (s1_idx < s1_lim);
    bus.i_s1_axis_TDATA  = W'(base1 + s1_idx);
    bus.i_eng_axis_TREADY = eng_rdy && (eng_cnt < N);
    if (eng_cnt == N) begin
      bus.i_eng_axis_TVALID = 1'b1;
      bus.i_eng_axis_TDATA  = eng_buf[tp(eng_oidx)];
    end else begin
      bus.i_eng_axis_TVALID = eng_force;
      bus.i_eng_axis_TDATA  = W'(24'h0ABCDE);
    end
    bus.i_m0_axis_TREADY = m0_rdy;
    bus.i_m1_axis_TREADY = m1_rdy;
  endtask

  // Record every handshake that the coming clock edge will complete.
  task automatic book();
    if (bus.o_busy && eng_cnt == N && !bus.o_owner) begin
      drain_cyc++;
      if (bus.o_eng_axis_TREADY !== bus.i_m0_axis_TREADY) mirror_bad++;
    end
    if ((bus.o_s1_axis_TREADY && !bus.o_owner) || (bus.o_s0_axis_TREADY && bus.o_owner)) cross_rdy++;
    if (bus.o_m1_axis_TVALID) m1_vld_seen++;
    if (bus.i_s0_axis_TVALID && bus.o_s0_axis_TREADY) s0_idx++;
    if (bus.i_s1_axis_TVALID && bus.o_s1_axis_TREADY) s1_idx++;
    if (bus.i_eng_axis_TVALID && bus.o_eng_axis_TREADY) begin
      if (eng_cnt < N) junk_taken++;
      else begin
        eng_oidx++;
        if (eng_oidx == N) begin eng_cnt = 0; eng_oidx = 0; end
      end
    end
    if (bus.o_eng_axis_TVALID && bus.i_eng_axis_TREADY) begin
      eng_buf[eng_cnt] = bus.o_eng_axis_TDATA;
      eng_q.push_back(bus.o_eng_axis_TDATA);
      eng_tl.push_back(bus.o_eng_axis_TLAST);
      eng_cnt++;
    end
    if (bus.o_m0_axis_TVALID && bus.i_m0_axis_TREADY) begin
      m0_q.push_back(bus.o_m0_axis_TDATA); m0_tl.push_back(bus.o_m0_axis_TLAST);
    end
    if (bus.o_m1_axis_TVALID && bus.i_m1_axis_TREADY) begin
      m1_q.push_back(bus.o_m1_axis_TDATA); m1_tl.push_back(bus.o_m1_axis_TLAST);
    end
    if (bus.o_busy && !busy_prev) owner_log.push_back(int'(bus.o_owner));
    busy_prev = bus.o_busy;
    if (m0_tog) m0_rdy = ~m0_rdy;
  endtask

  task automatic half(); drive(); #1; endtask
  task automatic fin();  book(); @(posedge clk); #1; endtask
  task automatic cyc();  half(); fin(); endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    clr();
  endtask

  task automatic run_m0(input int budget);
    for (int c = 0; c < budget && m0_q.size() < N; c++) cyc();
    vec_cnt++;
    if (m0_q.size() != N) begin
      err_cnt++; $display("FAIL m0_timeout: got %0d beats want %0d", m0_q.size(), N);
    end
  endtask

  task automatic test_reset();
    do_reset();
    half();
    vec_cnt++;
    if ({bus.o_s0_axis_TREADY, bus.o_s1_axis_TREADY, bus.o_eng_axis_TVALID, bus.o_eng_axis_TLAST,
         bus.o_eng_axis_TREADY, bus.o_m0_axis_TVALID, bus.o_m0_axis_TLAST, bus.o_m1_axis_TVALID,
         bus.o_m1_axis_TLAST, bus.o_busy, bus.o_owner} !== 11'b0) begin
      err_cnt++; $display("FAIL reset_ctrl: got nonzero control outputs want 0");
    end
    vec_cnt++;
    if ({bus.o_eng_axis_TDATA, bus.o_m0_axis_TDATA, bus.o_m1_axis_TDATA} !== {(3*W){1'b0}}) begin
      err_cnt++; $display("FAIL reset_data: got %0h/%0h/%0h want 0", bus.o_eng_axis_TDATA,
                          bus.o_m0_axis_TDATA, bus.o_m1_axis_TDATA);
    end
    fin();
    s0_en = 1;
    half();
    vec_cnt++;
    if ({bus.o_s0_axis_TREADY, bus.o_eng_axis_TVALID} !== 2'b00) begin
      err_cnt++; $display("FAIL idle_no_take: got rdy/vld %b%b want 00", bus.o_s0_axis_TREADY,
                          bus.o_eng_axis_TVALID);
    end
    fin();
    half();
    vec_cnt++;
    if ({bus.o_busy, bus.o_owner, bus.o_eng_axis_TVALID, bus.o_s0_axis_TREADY, bus.o_eng_axis_TLAST} !== 5'b10110) begin
      err_cnt++; $display("FAIL feed_entry: got busy/own/vld/rdy/last %b%b%b%b%b want 10110", bus.o_busy,
                          bus.o_owner, bus.o_eng_axis_TVALID, bus.o_s0_axis_TREADY, bus.o_eng_axis_TLAST);
    end
    vec_cnt++;
    if (bus.o_eng_axis_TDATA !== W'(1)) begin
      err_cnt++; $display("FAIL feed_first_data: got %0d want 1", bus.o_eng_axis_TDATA);
    end
    fin();
  endtask

  task automatic test_single();
    int bad, tl_n;
    do_reset();
    s0_en = 1;
    run_m0(400);
    cyc(); cyc();
    vec_cnt++;
    if (eng_q.size() != N) begin err_cnt++; $display("FAIL single_eng_cnt: got %0d want %0d", eng_q.size(), N); end
    bad = 0;
    for (int k = 0; k < eng_q.size(); k++) if (eng_q[k] !== W'(k + 1)) bad++;
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL single_eng_data: got %0d wrong beats want 0", bad); end
    tl_n = 0;
    for (int k = 0; k < eng_tl.size(); k++) tl_n += int'(eng_tl[k]);
    vec_cnt++;
    if (tl_n != 1 || eng_tl[N-1] !== 1'b1) begin
      err_cnt++; $display("FAIL single_eng_tlast: got %0d tlasts, last=%b want 1 on beat 64", tl_n, eng_tl[N-1]);
    end
    bad = 0;
    for (int k = 0; k < m0_q.size(); k++) begin
      if (m0_q[k] !== W'(tp(k) + 1)) bad++;
      if (m0_tl[k] !== (k == N - 1)) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL single_m0: got %0d bad data/tlast want 0", bad); end
    vec_cnt++;
    if (m1_vld_seen != 0) begin err_cnt++; $display("FAIL single_m1_idle: got %0d cycles want 0", m1_vld_seen); end
    half();
    vec_cnt++;
    if (bus.o_busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_after: got %b want 0", bus.o_busy); end
    fin();
  endtask

  task automatic test_fair();
    int bad;
    int exp_own [3];
    exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0;
    do_reset();
    s0_en = 1; s1_en = 1; s0_lim = 2 * N; s1_lim = 2 * N;
    for (int c = 0; c < 700 && owner_log.size() < 3; c++) cyc();
    vec_cnt++;
    if (owner_log.size() < 3) begin
      err_cnt++; $display("FAIL fair_timeout: got %0d grants want 3", owner_log.size());
    end else begin
      for (int g = 0; g < 3; g++) begin
        vec_cnt++;
        if (owner_log[g] != exp_own[g]) begin
          err_cnt++; $display("FAIL fair_owner%0d: got %0d want %0d", g, owner_log[g], exp_own[g]);
        end
      end
    end
    vec_cnt++;
    if (cross_rdy != 0) begin err_cnt++; $display("FAIL fair_cross_ready: got %0d cycles want 0", cross_rdy); end
    bad = 0;
    for (int k = 0; k < m1_q.size(); k++) if (m1_q[k] !== W'(tp(k) + 1001)) bad++;
    vec_cnt++;
    if (m1_q.size() != N || bad != 0) begin
      err_cnt++; $display("FAIL fair_m1_data: got %0d beats %0d bad want %0d beats 0 bad", m1_q.size(), bad, N);
    end
  endtask

  task automatic test_toggle();
    int bad;
    do_reset();
    s0_en = 1; base0 = 500; m0_tog = 1;
    run_m0(600);
    cyc(); cyc(); cyc();
    vec_cnt++;
    if (drain_cyc < N || mirror_bad != 0) begin
      err_cnt++; $display("FAIL toggle_mirror: got %0d bad of %0d drain cycles want 0", mirror_bad, drain_cyc);
    end
    bad = 0;
    for (int k = 0; k < m0_q.size(); k++) if (m0_q[k] !== W'(tp(k) + 500)) bad++;
    vec_cnt++;
    if (m0_q.size() != N || bad != 0) begin
      err_cnt++; $display("FAIL toggle_order: got %0d beats %0d bad want %0d beats 0 bad", m0_q.size(), bad, N);
    end
  endtask

  task automatic test_stall();
    int rdy_bad, dat_bad, bad, tl_n;
    do_reset();
    s0_en = 1;
    for (int c = 0; c < 100 && eng_cnt < 20; c++) cyc();
    vec_cnt++;
    if (eng_cnt != 20) begin err_cnt++; $display("FAIL stall_reach: got %0d beats want 20", eng_cnt); end
    eng_rdy = 0; rdy_bad = 0; dat_bad = 0;
    repeat (10) begin
      half();
      if (bus.o_s0_axis_TREADY !== 1'b0) rdy_bad++;
      if (bus.o_eng_axis_TDATA !== W'(21) || bus.o_eng_axis_TVALID !== 1'b1 || bus.o_eng_axis_TLAST !== 1'b0) dat_bad++;
      fin();
    end
    vec_cnt++;
    if (rdy_bad != 0) begin err_cnt++; $display("FAIL stall_s0_ready: got %0d high cycles want 0", rdy_bad); end
    vec_cnt++;
    if (dat_bad != 0) begin err_cnt++; $display("FAIL stall_hold_beat21: got %0d bad cycles want 0", dat_bad); end
    vec_cnt++;
    if (eng_cnt != 20) begin err_cnt++; $display("FAIL stall_count_hold: got %0d want 20", eng_cnt); end
    eng_rdy = 1;
    run_m0(400);
    bad = 0; tl_n = 0;
    for (int k = 0; k < eng_q.size(); k++) begin
      if (eng_q[k] !== W'(k + 1)) bad++;
      tl_n += int'(eng_tl[k]);
    end
    vec_cnt++;
    if (eng_q.size() != N || bad != 0 || tl_n != 1 || eng_tl[N-1] !== 1'b1) begin
      err_cnt++; $display("FAIL stall_resume: got %0d beats %0d bad %0d tlast want %0d/0/1", eng_q.size(), bad, tl_n, N);
    end
  endtask

  task automatic test_reset_mid();
    int tl_n;
    do_reset();
    s0_en = 1; s0_lim = 2 * N;
    for (int c = 0; c < 600 && !(m0_q.size() == N && eng_cnt == 30); c++) cyc();
    vec_cnt++;
    if (!(m0_q.size() == N && eng_cnt == 30)) begin
      err_cnt++; $display("FAIL rmid_reach: got %0d results %0d beats want %0d/30", m0_q.size(), eng_cnt, N);
    end
    s0_en = 0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    clr();
    s0_en = 1; s1_en = 1;
    half();
    vec_cnt++;
    if ({bus.o_s0_axis_TREADY, bus.o_s1_axis_TREADY, bus.o_eng_axis_TVALID, bus.o_eng_axis_TREADY,
         bus.o_m0_axis_TVALID, bus.o_m1_axis_TVALID, bus.o_busy} !== 7'b0) begin
      err_cnt++; $display("FAIL rmid_idle: got nonzero handshake/busy outputs want 0");
    end
    fin();
    half();
    vec_cnt++;
    if ({bus.o_busy, bus.o_owner} !== 2'b10) begin
      err_cnt++; $display("FAIL rmid_grant: got busy/owner %b%b want 10", bus.o_busy, bus.o_owner);
    end
    fin();
    run_m0(400);
    tl_n = 0;
    for (int k = 0; k < N && k < eng_tl.size(); k++) tl_n += int'(eng_tl[k]);
    vec_cnt++;
    if (eng_q.size() < N || eng_q[0] !== W'(1) || tl_n != 1 || eng_tl[N-1] !== 1'b1) begin
      err_cnt++; $display("FAIL rmid_fresh: got %0d beats first=%0d tlasts=%0d want >=%0d/1/1", eng_q.size(),
                          eng_q.size() > 0 ? eng_q[0] : 0, tl_n, N);
    end
  endtask

  task automatic test_early_eng();
    int feed_cyc, rdy_bad, m_bad, bad;
    do_reset();
    s0_en = 1; eng_force = 1;
    feed_cyc = 0; rdy_bad = 0; m_bad = 0;
    for (int c = 0; c < 400 && m0_q.size() < N; c++) begin
      half();
      if (bus.o_busy && eng_cnt < N) begin
        feed_cyc++;
        if (bus.o_eng_axis_TREADY !== 1'b0) rdy_bad++;
        if (bus.o_m0_axis_TVALID !== 1'b0 || bus.o_m1_axis_TVALID !== 1'b0) m_bad++;
      end
      fin();
    end
    vec_cnt++;
    if (feed_cyc < N || rdy_bad != 0 || junk_taken != 0) begin
      err_cnt++; $display("FAIL early_eng_ready: got %0d bad %0d junk over %0d feed cycles want 0/0",
                          rdy_bad, junk_taken, feed_cyc);
    end
    vec_cnt++;
    if (m_bad != 0) begin err_cnt++; $display("FAIL early_m_valid: got %0d cycles want 0", m_bad); end
    bad = 0;
    for (int k = 0; k < m0_q.size(); k++) if (m0_q[k] !== W'(tp(k) + 1)) bad++;
    vec_cnt++;
    if (m0_q.size() != N || bad != 0) begin
      err_cnt++; $display("FAIL early_m0_data: got %0d beats %0d bad want %0d/0", m0_q.size(), bad, N);
    end
  endtask

  initial begin
    clr();
    drive();
    test_reset();
    test_single();
    test_fair();
    test_toggle();
    test_stall();
    test_reset_mid();
    test_early_eng();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
